// File: rtl/mult_mux.sv
// Registered select-and-multiply stage feeding the convolution accumulator.
// Define MULT_MUX_SIGNED_EN for two's-complement operands; default build is unsigned.
module mult_mux #(
  parameter int DATA_W = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_valid_i,
  input  logic [1:0]            sel_i,
  input  logic [DATA_W-1:0]     a0_i,
  input  logic [DATA_W-1:0]     k0_i,
  input  logic [DATA_W-1:0]     a1_i,
  input  logic [DATA_W-1:0]     k1_i,
  input  logic [DATA_W-1:0]     a2_i,
  input  logic [DATA_W-1:0]     k2_i,
  output logic [2*DATA_W-1:0]   product_o,
  output logic                  out_valid_o,
  output logic                  sel_err_o
);

  localparam int PROD_W = 2 * DATA_W;

  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_k;
  logic [PROD_W-1:0] mul_res;
  logic [PROD_W-1:0] product_d, product_q;
  logic              sel_err_d, sel_err_q;
  logic              out_valid_q;

  always_comb begin
    op_a      = '0;
    op_k      = '0;
    sel_err_d = 1'b0;
    unique case (sel_i)
      2'd0: begin op_a = a0_i; op_k = k0_i; end
      2'd1: begin op_a = a1_i; op_k = k1_i; end
      2'd2: begin op_a = a2_i; op_k = k2_i; end
      default: sel_err_d = 1'b1;
    endcase
  end

`ifdef MULT_MUX_SIGNED_EN
  // Sign-extend to full product width so the low PROD_W bits are the exact signed result.
  logic signed [PROD_W-1:0] op_a_ext;
  logic signed [PROD_W-1:0] op_k_ext;
  assign op_a_ext = PROD_W'($signed(op_a));
  assign op_k_ext = PROD_W'($signed(op_k));
  assign mul_res  = op_a_ext * op_k_ext;
`else
  logic [PROD_W-1:0] op_a_ext;
  logic [PROD_W-1:0] op_k_ext;
  assign op_a_ext = {{DATA_W{1'b0}}, op_a};
  assign op_k_ext = {{DATA_W{1'b0}}, op_k};
  assign mul_res  = op_a_ext * op_k_ext;
`endif

  // The "no pair" code must never leak a product, even if the operand mux changes.
  assign product_d = sel_err_d ? '0 : mul_res;

  always_ff @(posedge clock) begin
    if (reset) begin
      product_q   <= '0;
      out_valid_q <= 1'b0;
      sel_err_q   <= 1'b0;
    end else if (in_valid_i) begin
      product_q   <= product_d;
      out_valid_q <= 1'b1;
      sel_err_q   <= sel_err_d;
    end else begin
      out_valid_q <= 1'b0;
    end
  end

  assign product_o   = product_q;
  assign out_valid_o = out_valid_q;
  assign sel_err_o   = sel_err_q;

endmodule

// File: tb/tb_mult_mux.sv
// Self-checking bench for mult_mux: directed steps then random traffic against
// an arithmetic reference model; honours MULT_MUX_SIGNED_EN like the design.
module tb_mult_mux;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid_i;
  logic [1:0]  sel_i;
  logic [7:0]  a0_i, k0_i, a1_i, k1_i, a2_i, k2_i;
  logic [15:0] product_o;
  logic        out_valid_o;
  logic        sel_err_o;

  int total = 0;
  int bad   = 0;

  logic [15:0] expProduct;
  logic        expValid;
  logic        expErr;

  mult_mux #(.DATA_W(8)) dut (
    .clock       (clock),
    .reset       (reset),
    .in_valid_i  (in_valid_i),
    .sel_i       (sel_i),
    .a0_i        (a0_i),
    .k0_i        (k0_i),
    .a1_i        (a1_i),
    .k1_i        (k1_i),
    .a2_i        (a2_i),
    .k2_i        (k2_i),
    .product_o   (product_o),
    .out_valid_o (out_valid_o),
    .sel_err_o   (sel_err_o)
  );

  always #5 clock = ~clock;

  function automatic int toNum(input logic [7:0] v);
`ifdef MULT_MUX_SIGNED_EN
    return (v > 8'd127) ? int'(v) - 256 : int'(v);
`else
    return int'(v);
`endif
  endfunction

  function automatic logic [15:0] modelProduct(input logic [1:0] s);
    logic [7:0] as [3];
    logic [7:0] ks [3];
    int r;
    as[0] = a0_i; as[1] = a1_i; as[2] = a2_i;
    ks[0] = k0_i; ks[1] = k1_i; ks[2] = k2_i;
    if (s == 2'd3) return 16'd0;
    r = toNum(as[s]) * toNum(ks[s]);
    return r[15:0];
  endfunction

  task automatic checkOutput(input string tag);
    total++;
    assert (product_o === expProduct) else begin
      bad++;
      $error("[TB] FAIL %s product got=%h exp=%h", tag, product_o, expProduct);
    end
    total++;
    assert (out_valid_o === expValid) else begin
      bad++;
      $error("[TB] FAIL %s out_valid got=%b exp=%b", tag, out_valid_o, expValid);
    end
    total++;
    assert (sel_err_o === expErr) else begin
      bad++;
      $error("[TB] FAIL %s sel_err got=%b exp=%b", tag, sel_err_o, expErr);
    end
  endtask

  task automatic checkValue(input string tag, input logic [15:0] want);
    total++;
    assert (product_o === want) else begin
      bad++;
      $error("[TB] FAIL %s product got=%h spec=%h", tag, product_o, want);
    end
  endtask

  task automatic applyStimulus(input string tag, input logic r, input logic v,
                               input logic [1:0] s);
    logic [15:0] nextProd;
    reset      = r;
    in_valid_i = v;
    sel_i      = s;
    nextProd   = modelProduct(s);
    @(posedge clock);
    if (r) begin
      expProduct = 16'd0; expValid = 1'b0; expErr = 1'b0;
    end else if (v) begin
      expProduct = nextProd; expValid = 1'b1; expErr = (s == 2'd3);
    end else begin
      expValid = 1'b0;
    end
    #1;
    checkOutput(tag);
  endtask

  initial begin
    expProduct = 16'd0; expValid = 1'b0; expErr = 1'b0;
    a0_i = 8'd3; k0_i = 8'd4; a1_i = 8'd5; k1_i = 8'd6; a2_i = 8'd7; k2_i = 8'd8;

    applyStimulus("reset1", 1'b1, 1'b1, 2'd0);
    applyStimulus("reset2", 1'b1, 1'b1, 2'd3);

    applyStimulus("sel0", 1'b0, 1'b1, 2'd0); checkValue("sel0_spec", 16'd12);
    applyStimulus("sel1", 1'b0, 1'b1, 2'd1); checkValue("sel1_spec", 16'd30);
    applyStimulus("sel2", 1'b0, 1'b1, 2'd2); checkValue("sel2_spec", 16'd56);
    applyStimulus("sel3", 1'b0, 1'b1, 2'd3); checkValue("sel3_spec", 16'd0);

    applyStimulus("sel1b", 1'b0, 1'b1, 2'd1);
    a1_i = 8'd9;
    applyStimulus("hold", 1'b0, 1'b0, 2'd2); checkValue("hold_spec", 16'd30);

    a2_i = 8'hFF; k2_i = 8'hFF;
    applyStimulus("max", 1'b0, 1'b1, 2'd2);
`ifdef MULT_MUX_SIGNED_EN
    checkValue("max_spec", 16'd1);
`else
    checkValue("max_spec", 16'hFE01);
`endif
    a0_i = 8'd0; k0_i = 8'hFF;
    applyStimulus("zero", 1'b0, 1'b1, 2'd0); checkValue("zero_spec", 16'd0);

    a1_i = 8'h80; k1_i = 8'h80;
    applyStimulus("m80", 1'b0, 1'b1, 2'd1); checkValue("m80_spec", 16'h4000);
    a1_i = 8'hFF; k1_i = 8'h02;
    applyStimulus("mff", 1'b0, 1'b1, 2'd1);
`ifdef MULT_MUX_SIGNED_EN
    checkValue("mff_spec", 16'hFFFE);
`else
    checkValue("mff_spec", 16'd510);
`endif
    a0_i = 8'hFD; k0_i = 8'd4;
    applyStimulus("mfd", 1'b0, 1'b1, 2'd0);
`ifdef MULT_MUX_SIGNED_EN
    checkValue("mfd_spec", 16'hFFF4);
`else
    checkValue("mfd_spec", 16'd1012);
`endif

    a2_i = 8'd7; k2_i = 8'd8;
    applyStimulus("midrst", 1'b1, 1'b1, 2'd2);
    applyStimulus("afterrst", 1'b0, 1'b1, 2'd2); checkValue("afterrst_spec", 16'd56);

    for (int i = 0; i < 300; i++) begin
      a0_i = 8'($urandom); k0_i = 8'($urandom);
      a1_i = 8'($urandom); k1_i = 8'($urandom);
      a2_i = 8'($urandom); k2_i = 8'($urandom);
      applyStimulus("rand", ($urandom_range(0, 19) == 0), 1'($urandom), 2'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
